// File: rtl/breakout_ball_ctrl.sv
// breakout_ball_ctrl: ball motion and game-state engine for the breakout
// playfield. Moves the ball once per frame (at end of frame), bounces it off
// whatever the playfield reports as drawn under the four edge probes, counts
// bricks and lives, and drives the brick hit / wall restore strobes.
//
// Ports:
//   clk, reset          pixel clock, synchronous active-high reset
//   CounterX/CounterY   current raster position
//   PaddleX             paddle left edge (serve reference)
//   launch              serve / restart request (level)
//   DrawBorder/Paddle/Brick  playfield draw flags, one cycle late
//   BrickHit_acq        brick destroyed, one cycle after BrickHit_now
//   ballX/ballY         ball top-left corner
//   BrickHit_now        ball covers the current pixel (PLAY only)
//   RestoreBrickwall    rebuild-wall strobe, high for one full frame
//   bricks_left, lives, game_over  game status
//
// Optional feature: define BREAKOUT_SPEEDUP_EN to move at 2 px/frame once
// 64 bricks have been cleared.
module breakout_ball_ctrl #(
  parameter int H_DRAW    = 640,
  parameter int V_DRAW    = 480,
  parameter int BALL_SIZE = 16,
  parameter int SERVE_Y   = 418,
  parameter int MISS_Y    = 440,
  parameter int BRICKS    = 133,
  parameter int LIVES     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] CounterX,
  input  logic [8:0] CounterY,
  input  logic [9:0] PaddleX,
  input  logic       launch,
  input  logic       DrawBorder,
  input  logic       DrawPaddle,
  input  logic       DrawBrick,
  input  logic       BrickHit_acq,
  output logic [9:0] ballX,
  output logic [8:0] ballY,
  output logic       BrickHit_now,
  output logic       RestoreBrickwall,
  output logic [7:0] bricks_left,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam logic [9:0]  RST_X    = 10'(H_DRAW / 2 - BALL_SIZE / 2);
  localparam logic [8:0]  SRV_Y    = 9'(SERVE_Y);
  localparam logic [8:0]  LOST_Y   = 9'(MISS_Y);
  localparam logic [8:0]  EOF_Y    = 9'(V_DRAW);
  localparam logic [9:0]  SERVE_DX = 10'd24;
  localparam logic [10:0] EDGE_X   = 11'(BALL_SIZE - 1);
  localparam logic [9:0]  EDGE_Y   = 10'(BALL_SIZE - 1);
  localparam logic [10:0] MID_LO_X = 11'(BALL_SIZE / 4);
  localparam logic [10:0] MID_HI_X = 11'(BALL_SIZE - BALL_SIZE / 4 - 1);
  localparam logic [9:0]  MID_LO_Y = 10'(BALL_SIZE / 4);
  localparam logic [9:0]  MID_HI_Y = 10'(BALL_SIZE - BALL_SIZE / 4 - 1);
  localparam logic [7:0]  BRICKS_N = 8'(BRICKS);
  localparam logic [1:0]  LIVES_N  = 2'(LIVES);

  typedef enum logic [1:0] {
    ST_RESTORE,
    ST_SERVE,
    ST_PLAY,
    ST_GAMEOVER
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] ball_x_q, ball_x_d;
  logic [8:0] ball_y_q, ball_y_d;
  // dir_x: 1 = right, dir_y: 1 = up
  logic       dir_x_q, dir_x_d;
  logic       dir_y_q, dir_y_d;
  logic       restore_q, restore_d;
  logic [7:0] bricks_q, bricks_d;
  logic [1:0] lives_q, lives_d;
  logic       game_over_q, game_over_d;
  logic       hit_l_q, hit_l_d;
  logic       hit_r_q, hit_r_d;
  logic       hit_t_q, hit_t_d;
  logic       hit_b_q, hit_b_d;
  logic [9:0] cx_dly_q;
  logic [8:0] cy_dly_q;

  logic        fs, eof;
  logic [10:0] bx_w, cx_w, cxd_w;
  logic [9:0]  by_w, cy_w, cyd_w;
  logic        obstacle, row_mid, col_mid;
  logic        probe_l, probe_r, probe_t, probe_b;
  logic        in_x, in_y;
  logic [9:0]  step_x;
  logic [8:0]  step_y;
  logic        dir_x_nx, dir_y_nx;

  assign fs  = (CounterX == 10'd0) && (CounterY == 9'd0);
  assign eof = (CounterX == 10'd0) && (CounterY == EOF_Y);

  // Geometry is compared one bit wider so ball+15 never wraps back
  // onto low coordinates.
  assign bx_w  = {1'b0, ball_x_q};
  assign by_w  = {1'b0, ball_y_q};
  assign cx_w  = {1'b0, CounterX};
  assign cy_w  = {1'b0, CounterY};
  assign cxd_w = {1'b0, cx_dly_q};
  assign cyd_w = {1'b0, cy_dly_q};

  assign obstacle = DrawBorder | DrawPaddle | DrawBrick;
  assign row_mid  = (cyd_w >= by_w + MID_LO_Y) && (cyd_w <= by_w + MID_HI_Y);
  assign col_mid  = (cxd_w >= bx_w + MID_LO_X) && (cxd_w <= bx_w + MID_HI_X);
  assign probe_l  = obstacle && (cxd_w == bx_w) && row_mid;
  assign probe_r  = obstacle && (cxd_w == bx_w + EDGE_X) && row_mid;
  assign probe_t  = obstacle && (cyd_w == by_w) && col_mid;
  assign probe_b  = obstacle && (cyd_w == by_w + EDGE_Y) && col_mid;

  assign in_x = (cx_w >= bx_w) && (cx_w <= bx_w + EDGE_X);
  assign in_y = (cy_w >= by_w) && (cy_w <= by_w + EDGE_Y);
  assign BrickHit_now = (state_q == ST_PLAY) && in_x && in_y;

`ifdef BREAKOUT_SPEEDUP_EN
  localparam logic [7:0] FAST_AT = 8'(BRICKS - 64);
  // bricks_left is reloaded on the wall rebuild, so speed drops back to 1
  assign step_x = (bricks_q <= FAST_AT) ? 10'd2 : 10'd1;
  assign step_y = (bricks_q <= FAST_AT) ? 9'd2 : 9'd1;
`else
  assign step_x = 10'd1;
  assign step_y = 9'd1;
`endif

  // Bounce only toward the side we are travelling; opposite-side hits
  // in the same frame cancel out.
  always_comb begin
    dir_x_nx = dir_x_q;
    dir_y_nx = dir_y_q;
    if (!(hit_l_q && hit_r_q)) begin
      if (hit_l_q && !dir_x_q) dir_x_nx = 1'b1;
      else if (hit_r_q && dir_x_q) dir_x_nx = 1'b0;
    end
    if (!(hit_t_q && hit_b_q)) begin
      if (hit_t_q && dir_y_q) dir_y_nx = 1'b0;
      else if (hit_b_q && !dir_y_q) dir_y_nx = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    restore_d   = restore_q;
    bricks_d    = bricks_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;

    if (eof) begin
      hit_l_d = 1'b0;
      hit_r_d = 1'b0;
      hit_t_d = 1'b0;
      hit_b_d = 1'b0;
    end else begin
      hit_l_d = hit_l_q | probe_l;
      hit_r_d = hit_r_q | probe_r;
      hit_t_d = hit_t_q | probe_t;
      hit_b_d = hit_b_q | probe_b;
    end

    if (BrickHit_acq && (bricks_q != 8'd0)) bricks_d = bricks_q - 8'd1;

    unique case (state_q)
      ST_RESTORE: begin
        // first FS raises the strobe, the following FS ends the sweep
        if (fs) begin
          if (!restore_q) begin
            restore_d = 1'b1;
          end else begin
            restore_d = 1'b0;
            bricks_d  = BRICKS_N;
            state_d   = ST_SERVE;
          end
        end
      end
      ST_SERVE: begin
        if (eof) begin
          ball_x_d = PaddleX + SERVE_DX;
          ball_y_d = SRV_Y;
          dir_y_d  = 1'b1;
          if (launch) state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (eof) begin
          if (bricks_q == 8'd0) begin
            state_d  = ST_RESTORE;
            ball_x_d = PaddleX + SERVE_DX;
            ball_y_d = SRV_Y;
            dir_y_d  = 1'b1;
          end else if (ball_y_q >= LOST_Y) begin
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_d     = ST_GAMEOVER;
              game_over_d = 1'b1;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            dir_x_d  = dir_x_nx;
            dir_y_d  = dir_y_nx;
            ball_x_d = dir_x_nx ? ball_x_q + step_x : ball_x_q - step_x;
            ball_y_d = dir_y_nx ? ball_y_q - step_y : ball_y_q + step_y;
          end
        end
      end
      ST_GAMEOVER: begin
        if (eof && launch) begin
          lives_d     = LIVES_N;
          game_over_d = 1'b0;
          state_d     = ST_RESTORE;
        end
      end
      default: state_d = ST_RESTORE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RESTORE;
      ball_x_q    <= RST_X;
      ball_y_q    <= SRV_Y;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      restore_q   <= 1'b0;
      bricks_q    <= BRICKS_N;
      lives_q     <= LIVES_N;
      game_over_q <= 1'b0;
      hit_l_q     <= 1'b0;
      hit_r_q     <= 1'b0;
      hit_t_q     <= 1'b0;
      hit_b_q     <= 1'b0;
      cx_dly_q    <= 10'd0;
      cy_dly_q    <= 9'd0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      restore_q   <= restore_d;
      bricks_q    <= bricks_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      hit_l_q     <= hit_l_d;
      hit_r_q     <= hit_r_d;
      hit_t_q     <= hit_t_d;
      hit_b_q     <= hit_b_d;
      cx_dly_q    <= CounterX;
      cy_dly_q    <= CounterY;
    end
  end

  assign ballX            = ball_x_q;
  assign ballY            = ball_y_q;
  assign RestoreBrickwall = restore_q;
  assign bricks_left      = bricks_q;
  assign lives            = lives_q;
  assign game_over        = game_over_q;

endmodule

// File: tb/tb_breakout_ball_ctrl.sv
// tb_breakout_ball_ctrl: compressed-raster bench for breakout_ball_ctrl.
// Frames are FS, a few chosen pixels, filler, EOF, idle; a frame-level model
// predicts every output and a negedge monitor pops and compares.
module tb_breakout_ball_ctrl;

  localparam int M_RESTORE = 0;
  localparam int M_SERVE   = 1;
  localparam int M_PLAY    = 2;
  localparam int M_OVER    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [9:0] CounterX;
  logic [8:0] CounterY;
  logic [9:0] PaddleX;
  logic       launch;
  logic       DrawBorder, DrawPaddle, DrawBrick, BrickHit_acq;
  logic [9:0] ballX;
  logic [8:0] ballY;
  logic       BrickHit_now, RestoreBrickwall;
  logic [7:0] bricks_left;
  logic [1:0] lives;
  logic       game_over;

  breakout_ball_ctrl dut (
    .clk(clk), .reset(reset),
    .CounterX(CounterX), .CounterY(CounterY), .PaddleX(PaddleX),
    .launch(launch), .DrawBorder(DrawBorder), .DrawPaddle(DrawPaddle),
    .DrawBrick(DrawBrick), .BrickHit_acq(BrickHit_acq),
    .ballX(ballX), .ballY(ballY), .BrickHit_now(BrickHit_now),
    .RestoreBrickwall(RestoreBrickwall), .bricks_left(bricks_left),
    .lives(lives), .game_over(game_over)
  );

  typedef struct {int x; int y; int kind;} ev_t;
  typedef struct {int bx; int by; int rst; int bricks; int lives; int go;} exp_t;

  ev_t  evs[$];
  exp_t fq[$];
  int   pq[$];
  int   rlq[$];

  int checks = 0;
  int failures = 0;
  bit pix_v = 0;
  bit frm_v = 0;
  int cyc_n = 0;
  int r_cnt = 0;

  // reference game state; directions as signed screen steps
  int m_st, m_bx, m_by, m_dx, m_dy, m_restore, m_bricks, m_lives, m_go;
  int m_pad, m_launch, r_start;
  bit m_hl, m_hr, m_ht, m_hb;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic lost(input string name);
    checks++;
    failures++;
    $display("FAIL %s: no expectation available", name);
  endtask

  always @(negedge clk) begin
    if (pix_v) begin
      if (pq.size() == 0) lost("brick_hit_now");
      else chk("brick_hit_now", int'(BrickHit_now), pq.pop_front());
    end
    if (frm_v) begin
      if (fq.size() == 0) begin
        lost("frame");
      end else begin
        exp_t e;
        e = fq.pop_front();
        chk("ballX", int'(ballX), e.bx);
        chk("ballY", int'(ballY), e.by);
        chk("restore", int'(RestoreBrickwall), e.rst);
        chk("bricks_left", int'(bricks_left), e.bricks);
        chk("lives", int'(lives), e.lives);
        chk("game_over", int'(game_over), e.go);
      end
    end
    if (reset) begin
      r_cnt = 0;
    end else if (RestoreBrickwall) begin
      r_cnt++;
    end else if (r_cnt > 0) begin
      if (rlq.size() == 0) lost("restore_len");
      else chk("restore_len", r_cnt, rlq.pop_front());
      r_cnt = 0;
    end
  end

  function automatic int hit_now(input int x, input int y);
    return (m_st == M_PLAY && x >= m_bx && x <= m_bx + 15 &&
            y >= m_by && y <= m_by + 15) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_st = M_RESTORE; m_bx = 312; m_by = 418; m_dx = 1; m_dy = -1;
    m_restore = 0; m_bricks = 133; m_lives = 3; m_go = 0;
  endtask

  task automatic probe(input int x, input int y);
    if (x == m_bx && y >= m_by + 4 && y <= m_by + 11) m_hl = 1;
    if (x == m_bx + 15 && y >= m_by + 4 && y <= m_by + 11) m_hr = 1;
    if (y == m_by && x >= m_bx + 4 && x <= m_bx + 11) m_ht = 1;
    if (y == m_by + 15 && x >= m_bx + 4 && x <= m_bx + 11) m_hb = 1;
  endtask

  task automatic model_eof();
    int spd;
    spd = 1;
`ifdef BREAKOUT_SPEEDUP_EN
    if (m_bricks <= 133 - 64) spd = 2;
`endif
    case (m_st)
      M_SERVE: begin
        m_bx = (m_pad + 24) % 1024; m_by = 418; m_dy = -1;
        if (m_launch != 0) m_st = M_PLAY;
      end
      M_PLAY: begin
        if (m_bricks == 0) begin
          m_st = M_RESTORE; m_bx = (m_pad + 24) % 1024; m_by = 418; m_dy = -1;
        end else if (m_by >= 440) begin
          if (m_lives == 1) begin m_st = M_OVER; m_go = 1; end
          else m_st = M_SERVE;
          m_lives--;
        end else begin
          if (!(m_hl && m_hr)) begin
            if (m_hl && m_dx < 0) m_dx = 1;
            else if (m_hr && m_dx > 0) m_dx = -1;
          end
          if (!(m_ht && m_hb)) begin
            if (m_ht && m_dy < 0) m_dy = 1;
            else if (m_hb && m_dy > 0) m_dy = -1;
          end
          m_bx = (m_bx + m_dx * spd + 1024) % 1024;
          m_by = (m_by + m_dy * spd + 512) % 512;
        end
      end
      M_OVER: begin
        if (m_launch != 0) begin m_lives = 3; m_go = 0; m_st = M_RESTORE; end
      end
      default: ;
    endcase
  endtask

  task automatic cyc(input int x, input int y, input int kprev, input bit acq,
                     input bit pchk, input bit fchk);
    exp_t e;
    CounterX = 10'(x); CounterY = 9'(y);
    DrawBorder = (kprev == 1); DrawPaddle = (kprev == 2); DrawBrick = (kprev == 3);
    BrickHit_acq = acq;
    pix_v = pchk;
    if (pchk) pq.push_back(hit_now(x, y));
    frm_v = fchk;
    if (fchk) begin
      e.bx = m_bx; e.by = m_by; e.rst = m_restore;
      e.bricks = m_bricks; e.lives = m_lives; e.go = m_go;
      fq.push_back(e);
    end
    @(posedge clk); #1;
    cyc_n++;
    pix_v = 0; frm_v = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1, 480, 0, 0, 0, 0);
    cyc(1, 480, 0, 0, 0, 0);
    reset = 1'b0;
    model_reset();
    cyc(1, 480, 0, 0, 1, 1);
  endtask

  task automatic add_ev(input int x, input int y, input int k);
    ev_t e;
    e.x = ((x % 1024) + 1024) % 1024;
    e.y = ((y % 512) + 512) % 512;
    if (e.x == 0 && (e.y == 0 || e.y == 480)) e.x = 1;
    e.kind = k;
    evs.push_back(e);
  endtask

  task automatic add_probe(input int side, input int off, input int k);
    case (side)
      0: add_ev(m_bx, m_by + off, k);
      1: add_ev(m_bx + 15, m_by + off, k);
      2: add_ev(m_bx + off, m_by, k);
      default: add_ev(m_bx + off, m_by + 15, k);
    endcase
  endtask

  task automatic add_rand_px(input int k);
    add_ev(m_bx + int'($urandom_range(0, 19)) - 2,
           m_by + int'($urandom_range(0, 19)) - 2, k);
  endtask

  task automatic add_rand_evs();
    int n;
    n = int'($urandom_range(0, 4));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1)
        add_probe(int'($urandom_range(0, 3)), int'($urandom_range(3, 12)),
                  int'($urandom_range(0, 3)));
      else
        add_rand_px(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic run_frame(input int pad, input bit lch);
    int fs_k, kp;
    bit ap;
    PaddleX = 10'(pad); launch = lch;
    m_pad = pad; m_launch = lch;
    m_hl = 0; m_hr = 0; m_ht = 0; m_hb = 0;
    fs_k = cyc_n;
    cyc(0, 0, 0, 0, 1, 0);
    if (m_st == M_RESTORE) begin
      if (m_restore == 0) begin
        m_restore = 1; r_start = fs_k;
      end else begin
        m_restore = 0; m_bricks = 133; m_st = M_SERVE;
        rlq.push_back(fs_k - r_start);
      end
    end
    kp = 0; ap = 0;
    foreach (evs[i]) begin
      cyc(evs[i].x, evs[i].y, kp, ap, 1, 0);
      if (evs[i].kind != 0) probe(evs[i].x, evs[i].y);
      kp = evs[i].kind;
      ap = (kp == 3) && (hit_now(evs[i].x, evs[i].y) == 1);
      if (ap && m_bricks > 0) m_bricks--;
    end
    cyc(799, 500, kp, ap, 1, 0);
    cyc(0, 480, 0, 0, 1, 0);
    model_eof();
    cyc(1, 480, 0, 0, 1, 1);
    evs.delete();
  endtask

  initial begin
    reset = 1'b1; CounterX = '0; CounterY = '0; PaddleX = '0; launch = 1'b0;
    DrawBorder = 1'b0; DrawPaddle = 1'b0; DrawBrick = 1'b0; BrickHit_acq = 1'b0;
    model_reset();
    @(posedge clk); #1;

    do_reset();
    add_rand_evs();
    run_frame(0, 0);
    // reset in the middle of the wall sweep
    do_reset();
    add_rand_evs();
    run_frame(0, 0);
    add_rand_evs();
    run_frame(0, 0);

    // serve and first step up-right
    run_frame(200, 1);
    run_frame(200, 0);
    // top probe flips vertical direction
    add_probe(2, 8, 1);
    run_frame(200, 0);

    // keep the ball bouncing and break one brick per frame
    for (int f = 0; f < 150; f++) begin
      add_probe(m_dy < 0 ? 2 : 3, 8, 1);
      add_ev(m_bx + 8, m_by + 8, 3);
      run_frame(100, 1);
    end

    // steer downward until every life is lost
    for (int f = 0; f < 600 && m_st != M_OVER; f++) begin
      if (m_dy < 0) add_probe(2, 8, 1);
      run_frame(300, 1);
    end
    run_frame(300, 0);
    run_frame(300, 0);
    run_frame(300, 1);
    run_frame(300, 0);
    run_frame(300, 0);

    for (int f = 0; f < 2000; f++) begin
      add_rand_evs();
      run_frame(int'($urandom_range(0, 600)), $urandom_range(0, 3) == 0);
    end

    cyc(1, 480, 0, 0, 0, 0);
    cyc(1, 480, 0, 0, 0, 0);
    if (pq.size() != 0 || fq.size() != 0 || rlq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL queue_drain: pix=%0d frame=%0d restore=%0d left over",
               pq.size(), fq.size(), rlq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
